// File: rtl/myproject_acc_quant.sv
// myproject_acc_quant
//   Accumulates N_TERMS signed product terms per output group. The first term
//   of each group is seeded with the bias, pre-shifted to product scale. When
//   the last term is accepted, the sum is rounded (half toward +inf), shifted
//   down by FRAC_SHIFT, saturated to OUT_WIDTH and registered. A group whose
//   result has not yet been taken can hand over to the next group with no
//   idle cycle between them.
//
//   Optional feature macro: MYPROJECT_ACC_RELU_EN
//     defined   -> negative saturated results are clamped to 0 (fused ReLU)
//     undefined -> the signed saturated result passes through unchanged
//     Latency is the same in both builds.
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst     in   synchronous active-high reset
//   in_data    in   signed product term   [PROD_WIDTH]
//   in_valid   in   in_data valid
//   in_ready   out  term accepted this cycle when in_valid is also high
//   bias       in   signed bias at output scale [OUT_WIDTH], sampled on a group's first beat
//   out_data   out  rounded, saturated result   [OUT_WIDTH]
//   out_valid  out  out_data valid
//   out_ready  in   downstream takes out_data
//   busy       out  at least one term of the current group is accumulated
module myproject_acc_quant #(
    parameter int N_TERMS    = 9,
    parameter int PROD_WIDTH = 29,
    parameter int ACC_WIDTH  = 34,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 10
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic signed [PROD_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [OUT_WIDTH-1:0]  bias,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    // Rounding constant and output limits, all at full accumulator width so
    // the saturation compare sees every bit of the shifted sum.
    localparam logic signed [ACC_WIDTH-1:0] RND =
        {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic {ACC, DONE} state_t;

    state_t                        state;
    logic [CNT_W-1:0]              cnt;
    logic signed [ACC_WIDTH-1:0]   acc;

    logic                          accept;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   bias_ext;
    logic signed [ACC_WIDTH-1:0]   base;
    logic signed [ACC_WIDTH-1:0]   sum_next;
    logic signed [ACC_WIDTH-1:0]   rounded;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic signed [OUT_WIDTH-1:0]   q_next;

    // In DONE the slot frees up exactly when downstream takes the result,
    // which is what allows the zero-bubble hand-over to the next group.
    assign in_ready = !ap_rst && ((state == ACC) || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (cnt != '0);

    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};
    assign bias_ext = {{(ACC_WIDTH-OUT_WIDTH){bias[OUT_WIDTH-1]}}, bias};

    always_comb begin
        base     = (cnt == '0) ? (bias_ext <<< FRAC_SHIFT) : acc;
        sum_next = base + prod_ext;
        rounded  = sum_next + RND;
        shifted  = rounded >>> FRAC_SHIFT;
        q_next   = shifted[OUT_WIDTH-1:0];
        if (shifted > SAT_MAX)
            q_next = OUT_MAX;
        else if (shifted < SAT_MIN)
            q_next = OUT_MIN;
`ifdef MYPROJECT_ACC_RELU_EN
        if (q_next[OUT_WIDTH-1])
            q_next = '0;
`endif
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state     <= ACC;
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if ((state == DONE) && out_ready) begin
                state     <= ACC;
                out_valid <= 1'b0;
            end
            // Placed after the transfer so that a group completing in the
            // same cycle (N_TERMS==1) keeps the FSM in DONE with new data.
            if (accept) begin
                acc <= sum_next;
                if (cnt == LAST) begin
                    cnt       <= '0;
                    state     <= DONE;
                    out_valid <= 1'b1;
                    out_data  <= q_next;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_myproject_acc_quant.sv
module tb_myproject_acc_quant;

    localparam int NT = 9;
    localparam int FS = 10;

    logic               ap_clk = 1'b0;
    logic               ap_rst = 1'b1;
    logic signed [28:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] bias = '0;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               busy;

    int n_checks = 0;
    int n_pass   = 0;

    myproject_acc_quant dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .bias(bias),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int    b;
        int    first;
        int    rest;
        longint expect_q;
        string name;
    } vec_t;

    // Reference: exact integer sum, round half up, floor shift, clamp, optional ReLU.
    function automatic longint ref_q(input longint sum);
        longint q;
        q = (sum + (64'sd1 <<< (FS - 1))) >>> FS;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`ifdef MYPROJECT_ACC_RELU_EN
        if (q < 0) q = 0;
`endif
        return q;
    endfunction

    function automatic longint relu(input longint v);
`ifdef MYPROJECT_ACC_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input longint act, input longint exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Nine back-to-back beats; leaves the DUT in DONE just after the last edge.
    task automatic send_group(input int b, input int first, input int rest, input logic ordy);
        out_ready = ordy;
        for (int i = 0; i < NT; i++) begin
            in_valid = 1'b1;
            bias     = 16'(b);
            in_data  = 29'((i == 0) ? first : rest);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{5,          512,          512, relu(10),     "bias5_512"});
        vecs.push_back('{0,          512,            0, relu(1),      "tie_pos_half"});
        vecs.push_back('{0,         -512,            0, relu(0),      "tie_neg_half"});
        vecs.push_back('{0,         -513,            0, relu(-1),     "below_neg_half"});
        vecs.push_back('{0,    134217728,    134217728, relu(32767),  "sat_pos"});
        vecs.push_back('{0,   -134217728,   -134217728, relu(-32768), "sat_neg"});
        vecs.push_back('{-32768,       0,            0, relu(-32768), "bias_min"});
        vecs.push_back('{32767,      511,            0, relu(32767),  "bias_max_nosat"});
        vecs.push_back('{32767,      512,            0, relu(32767),  "bias_max_sat"});
        vecs.push_back('{0,         1536,            0, relu(2),      "tie_1p5"});
        vecs.push_back('{0,        -1536,            0, relu(-1),     "tie_m1p5"});
        vecs.push_back('{-3,         100,          -50, relu(-3),     "mixed"});

        // Reset and idle
        ap_rst = 1'b1;
        step(); step();
        chk("in_ready_in_reset", in_ready, 0);
        ap_rst = 1'b0;
        step(); step();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_data", out_data, 0);

        // Table-driven groups
        foreach (vecs[k]) begin
            send_group(vecs[k].b, vecs[k].first, vecs[k].rest, 1'b1);
            chk({vecs[k].name, "_valid"}, out_valid, 1);
            chk(vecs[k].name, out_data, vecs[k].expect_q);
            drain();
            chk({vecs[k].name, "_xfer"}, out_valid, 0);
        end

        // Back-pressure hold, then zero-bubble hand-over
        send_group(5, 512, 512, 1'b0);
        in_valid = 1'b1;
        in_data  = 29'(1024);
        bias     = 16'(0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, relu(10));
            chk("hold_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("handover_in_ready", in_ready, 1);
        step();
        chk("handover_xfer", out_valid, 0);
        chk("handover_busy", busy, 1);
        for (int i = 1; i < NT; i++) step();
        in_valid = 1'b0;
        chk("handover_result_valid", out_valid, 1);
        chk("handover_result", out_data, 9);
        drain();

        // Reset mid-group discards the partial sum
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 29'(777); bias = 16'(100);
            step();
        end
        chk("pre_reset_busy", busy, 1);
        in_valid = 1'b0;
        ap_rst = 1'b1;
        #1;
        chk("reset_in_ready", in_ready, 0);
        step();
        ap_rst = 1'b0;
        #1;
        chk("post_reset_busy", busy, 0);
        chk("post_reset_valid", out_valid, 0);
        send_group(0, 1024, 1024, 1'b1);
        chk("post_reset_result", out_data, 9);
        drain();
        step(); step();
        chk("post_reset_single", out_valid, 0);

        // Randomized traffic against a scoreboard
        begin
            longint q[$];
            longint msum;
            int     mcnt;
            logic   xfer, acc_b;
            mcnt = 0;
            msum = 0;
            for (int c = 0; c < 3000; c++) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
                bias      = 16'($urandom);
                if ($urandom_range(0, 3) == 0)
                    in_data = 29'($urandom);
                else
                    in_data = 29'(int'($urandom_range(0, 65535)) - 32768);
                #1;
                if (out_valid != (q.size() > 0))
                    chk("rnd_out_valid", out_valid, q.size() > 0);
                chk("rnd_busy", busy, mcnt != 0);
                chk("rnd_in_ready", in_ready, (q.size() == 0) || out_ready);
                xfer  = out_valid && out_ready;
                acc_b = in_valid && in_ready;
                if (xfer) begin
                    if (q.size() == 0)
                        chk("rnd_spurious_result", 1, 0);
                    else
                        chk("rnd_result", out_data, q.pop_front());
                end
                if (acc_b) begin
                    if (mcnt == 0) msum = longint'(bias) * 1024 + longint'(in_data);
                    else           msum = msum + longint'(in_data);
                    mcnt++;
                    if (mcnt == NT) begin
                        q.push_back(ref_q(msum));
                        mcnt = 0;
                    end
                end
                @(posedge ap_clk);
                #1;
                if (!xfer && out_valid && q.size() > 0 && !out_ready) begin
                    // result must not change while stalled: compared on next pass
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Output must hold while stalled
    logic signed [15:0] prev_data;
    logic               prev_stall = 1'b0;
    always @(posedge ap_clk) begin
        if (prev_stall && !ap_rst) begin
            chk("stall_stable_valid", out_valid, 1);
            chk("stall_stable_data", out_data, prev_data);
        end
        prev_stall = out_valid && !out_ready && !ap_rst;
        prev_data  = out_data;
    end

endmodule
